// File: rtl/wb_trace_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_trace_pkg
// Description : Shared defaults, entry layout and helpers for the writeback
//               trace capture FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_trace_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 16;
    localparam int TS_W_DEF   = 16;
    localparam int DROP_W_DEF = 8;

    // One stored entry is {timestamp, writeback value}
    localparam int ENTRY_W    = DATA_W_DEF + TS_W_DEF;
    localparam int DATA_LSB   = 0;
    localparam int DATA_MSB   = DATA_W_DEF - 1;
    localparam int TS_LSB     = DATA_W_DEF;
    localparam int TS_MSB     = ENTRY_W - 1;

    typedef struct packed {
        logic [TS_W_DEF-1:0]   ts;
        logic [DATA_W_DEF-1:0] data;
    } trace_entry_t;

    // Occupancy counter width: one extra bit so DEPTH itself is representable
    function automatic int count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_trace_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_trace_if
// Description : Capture-side and drain-side signals of the writeback trace
//               FIFO. The slave modport is the FIFO; master is its user.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_trace_if
    import wb_trace_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int TS_W   = TS_W_DEF,
    parameter int DROP_W = DROP_W_DEF
);
    logic                     wb_valid;
    logic [DATA_W-1:0]        wb_data;
    logic                     clear;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    logic [TS_W-1:0]          out_ts;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic [DROP_W-1:0]        drop_cnt;

    modport slave (
        input  wb_valid, wb_data, clear, out_ready,
        output out_valid, out_data, out_ts, count, overflow, drop_cnt
    );

    modport master (
        output wb_valid, wb_data, clear, out_ready,
        input  out_valid, out_data, out_ts, count, overflow, drop_cnt
    );

endinterface
`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_fwft
// Description : First-word-fall-through synchronous FIFO with a registered
//               head output. Pointers carry one extra wrap bit.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_fwft #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 16
) (
    input  wire logic                       clk,
    input  wire logic                       reset,
    input  wire logic                       clear,
    input  wire logic                       push,
    input  wire logic                       pop,
    input  wire logic [WIDTH-1:0]           wdata,
    output logic      [WIDTH-1:0]           rdata,
    output logic      [$clog2(DEPTH):0]     count,
    output logic                            full,
    output logic                            empty
);
    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic [WIDTH-1:0] r_rdata;

    logic             w_pop_ok;
    logic             w_push_ok;
    logic             w_bypass;
    logic [c_aw:0]    w_rd_next;

    assign count     = r_wr_ptr - r_rd_ptr;
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                       (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);

    // Guard against misuse: never pop empty, never push full without a pop
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);
    assign w_rd_next = r_rd_ptr + {{c_aw{1'b0}}, w_pop_ok};

    // The incoming word becomes the new head when nothing else survives the pop
    assign w_bypass  = w_push_ok && (count == {{c_aw{1'b0}}, w_pop_ok});

    assign rdata     = r_rdata;

    // Storage array, written on push; contents need no reset
    always_ff @(posedge clk) begin
        if (w_push_ok && !clear) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= wdata;
        end
    end

    // Read/write pointers with flush
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr <= w_rd_next;
        end
    end

    // Registered head: load the bypassed write or the next stored entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata <= '0;
        end else if (clear) begin
            r_rdata <= '0;
        end else if (w_bypass) begin
            r_rdata <= wdata;
        end else if (w_pop_ok) begin
            r_rdata <= r_mem[w_rd_next[c_aw-1:0]];
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_trace_fifo
// Description : Timestamps core writeback values and buffers them for a
//               valid/ready debug consumer. Drops are counted, never silent.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_trace_fifo
    import wb_trace_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int TS_W   = TS_W_DEF,
    parameter int DROP_W = DROP_W_DEF
) (
    input  wire logic   clk,
    input  wire logic   reset,
    wb_trace_if.slave   bus
);
    localparam int c_entry_w = DATA_W + TS_W;

    logic [TS_W-1:0]      r_ts;
    logic                 r_overflow;
    logic [DROP_W-1:0]    r_drop_cnt;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_drop;
    logic [c_entry_w-1:0] w_wentry;
    logic [c_entry_w-1:0] w_rentry;

    // clear wins over everything; a capture during clear is neither kept nor dropped
    assign w_pop    = !w_empty && bus.out_ready && !bus.clear;
    assign w_push   = bus.wb_valid && (!w_full || w_pop) && !bus.clear;
    assign w_drop   = bus.wb_valid && w_full && !w_pop && !bus.clear;
    assign w_wentry = {r_ts, bus.wb_data};

    assign bus.out_valid = !w_empty;
    assign bus.out_data  = w_rentry[DATA_W-1:0];
    assign bus.out_ts    = w_rentry[c_entry_w-1:DATA_W];
    assign bus.overflow  = r_overflow;
    assign bus.drop_cnt  = r_drop_cnt;

    sync_fifo_fwft #(
        .WIDTH (c_entry_w),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (bus.clear),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (w_wentry),
        .rdata (w_rentry),
        .count (bus.count),
        .full  (w_full),
        .empty (w_empty)
    );

    // Free-running timestamp, wraps naturally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ts <= '0;
        end else if (bus.clear) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
        end
    end

    // Sticky overflow flag and saturating drop counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (bus.clear) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != {DROP_W{1'b1}}) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_trace_fifo
// Description : Self-checking bench for wb_trace_fifo against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_trace_fifo;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int TS_W   = 16;
    localparam int DROP_W = 8;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    wb_trace_if #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W), .DROP_W(DROP_W)
    ) bus_if ();

    wb_trace_fifo #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W), .DROP_W(DROP_W)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: ordered list of {ts, data}, cycle stamp, drop tally
    logic [TS_W+DATA_W-1:0] m_q[$];
    logic [TS_W-1:0]        m_ts;
    logic                   m_ovf;
    int                     m_drops;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ts    = '0;
        m_ovf   = 1'b0;
        m_drops = 0;
    endtask

    task automatic check_all();
        check("out_valid", 64'(bus_if.out_valid), 64'(m_q.size() != 0));
        check("count", 64'(bus_if.count), 64'(m_q.size()));
        check("overflow", 64'(bus_if.overflow), 64'(m_ovf));
        check("drop_cnt", 64'(bus_if.drop_cnt), 64'(m_drops));
        if (m_q.size() != 0) begin
            check("out_data", 64'(bus_if.out_data), 64'(m_q[0][DATA_W-1:0]));
            check("out_ts", 64'(bus_if.out_ts), 64'(m_q[0][TS_W+DATA_W-1:DATA_W]));
        end
    endtask

    // One clock cycle: drive at negedge, advance model, check after the edge
    task automatic step(input logic v, input logic [DATA_W-1:0] d,
                        input logic rdy, input logic clr);
        bit do_pop;
        bus_if.wb_valid  = v;
        bus_if.wb_data   = d;
        bus_if.out_ready = rdy;
        bus_if.clear     = clr;
        if (clr) begin
            model_reset();
        end else begin
            do_pop = (m_q.size() != 0) && rdy;
            if (do_pop) void'(m_q.pop_front());
            if (v) begin
                if (m_q.size() < DEPTH) begin
                    m_q.push_back({m_ts, d});
                end else begin
                    m_ovf = 1'b1;
                    if (m_drops < DROP_MAX) m_drops++;
                end
            end
            m_ts = m_ts + 1'b1;
        end
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_if.wb_valid  = 1'b0;
        bus_if.wb_data   = '0;
        bus_if.out_ready = 1'b0;
        bus_if.clear     = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(bus_if.out_valid), 64'd0);
        check("rst_count", 64'(bus_if.count), 64'd0);
        check("rst_data", 64'(bus_if.out_data), 64'd0);
        check("rst_ts", 64'(bus_if.out_ts), 64'd0);
        check("rst_ovf", 64'(bus_if.overflow), 64'd0);
        check("rst_drop", 64'(bus_if.drop_cnt), 64'd0);
        reset = 1'b1;

        // Single capture at ts=3 appears next cycle
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 32'h5, 1'b0, 1'b0);
        check("t1_data", 64'(bus_if.out_data), 64'h5);
        check("t1_ts", 64'(bus_if.out_ts), 64'd3);
        check("t1_count", 64'(bus_if.count), 64'd1);
        step(1'b0, '0, 1'b1, 1'b0);

        // Fill to full without pops, then drain in order
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
        check("fill_count", 64'(bus_if.count), 64'd16);
        check("fill_ovf", 64'(bus_if.overflow), 64'd0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Full plus three captures with no pop: three drops
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 32'hDEAD0000 + 32'(i), 1'b0, 1'b0);
        check("drop3_cnt", 64'(bus_if.drop_cnt), 64'd3);
        check("drop3_head", 64'(bus_if.out_data), 64'h200);

        // Fresh full FIFO with push and pop together: no drops
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 32'h400 + 32'(i), 1'b1, 1'b0);
        check("pp_count", 64'(bus_if.count), 64'd16);
        check("pp_drop", 64'(bus_if.drop_cnt), 64'd0);
        check("pp_head", 64'(bus_if.out_data), 64'h304);

        // Saturating drop counter, then clear with a coincident capture
        for (int i = 0; i < 300; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        check("sat_drop", 64'(bus_if.drop_cnt), 64'd255);
        step(1'b1, 32'hCAFE, 1'b0, 1'b1);
        check("clr_count", 64'(bus_if.count), 64'd0);
        check("clr_valid", 64'(bus_if.out_valid), 64'd0);
        check("clr_ovf", 64'(bus_if.overflow), 64'd0);
        check("clr_drop", 64'(bus_if.drop_cnt), 64'd0);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 60, $urandom,
                 $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 2);
        end

        // Timestamp wrap across consecutive captures
        step(1'b0, '0, 1'b0, 1'b1);
        while (m_ts != 16'hFFFF) step(1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 32'hAAAA, 1'b0, 1'b0);
        step(1'b1, 32'hBBBB, 1'b0, 1'b0);
        check("wrap_ts0", 64'(bus_if.out_ts), 64'hFFFF);
        step(1'b0, '0, 1'b1, 1'b0);
        check("wrap_ts1", 64'(bus_if.out_ts), 64'h0000);
        check("wrap_data1", 64'(bus_if.out_data), 64'hBBBB);

        // Asynchronous reset in the middle of a drain
        for (int i = 0; i < 3; i++) step(1'b1, 32'h500 + 32'(i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        bus_if.out_ready = 1'b1;
        reset = 1'b0;
        #1;
        check("arst_valid", 64'(bus_if.out_valid), 64'd0);
        check("arst_count", 64'(bus_if.count), 64'd0);
        check("arst_data", 64'(bus_if.out_data), 64'd0);
        check("arst_ts", 64'(bus_if.out_ts), 64'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 32'h77, 1'b0, 1'b0);
        check("post_rst_ts", 64'(bus_if.out_ts), 64'd0);
        check("post_rst_data", 64'(bus_if.out_data), 64'h77);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_trace_fifo.md
Name: wb_trace_fifo

Overview:
Writeback trace capture stage that sits directly downstream of the RV32I core and consumes its 32-bit writeback value (WBout) each retire cycle. It timestamps each value with a free-running cycle counter and buffers the pair in a FIFO. A valid/ready port drains the FIFO to a debug consumer such as a bench scoreboard or a UART dumper. Overflow is counted, never silent.

Parameters:
DATA_W, 32, width of captured writeback value
DEPTH, 16, FIFO entries; power of two, >= 2
TS_W, 16, timestamp counter width
DROP_W, 8, saturating drop-counter width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted at 0)
wb_valid  in  1  core retired an instruction with a writeback this cycle
wb_data  in  DATA_W  writeback value (core WBout)
clear  in  1  synchronous flush of FIFO, counters and flags
out_valid  out  1  head entry available
out_ready  in  1  consumer accepts head this cycle
out_data  out  DATA_W  head writeback value
out_ts  out  TS_W  head timestamp
count  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky: at least one capture dropped
drop_cnt  out  DROP_W  number of dropped captures, saturating

Behaviour:
- Reset (reset==0, async): wr/rd pointers, count, ts counter, overflow, drop_cnt all 0; out_valid=0; out_data/out_ts=0. Memory contents are don't-care.
- ts counter: increments every cycle after reset release, wraps from 2^TS_W-1 to 0. The captured ts is the counter value in the cycle wb_valid is sampled.
- push = wb_valid && (!full || pop); pop = out_valid && out_ready.
- Write: on push, mem[wr_ptr] <= {ts, wb_data}; wr_ptr increments modulo DEPTH.
- Read: first-word-fall-through. out_valid = (count != 0). out_data/out_ts show mem[rd_ptr] registered, with no combinational path from wb_data. On pop, rd_ptr increments modulo DEPTH.
- Latency: an entry pushed into an empty FIFO in cycle N is visible on out_valid/out_data in cycle N+1.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full with simultaneous wb_valid and pop: both occur; count stays DEPTH; no drop.
- Full, wb_valid, no pop: entry dropped. overflow <= 1. drop_cnt increments and saturates at 2^DROP_W-1.
- Empty with out_ready=1: no effect; pointers unchanged.
- Pointer wrap: pointers carry one extra MSB. full = MSBs differ and lower bits equal.
- clear (sync): priority over push/pop in the same cycle. Next cycle: count=0, pointers=0, overflow=0, drop_cnt=0, ts=0. A wb_valid coincident with clear is discarded and not counted as a drop.
- Async reset mid-stream: all state returns to reset values immediately. The first capture after release carries ts=0 if sampled in the first cycle.
- Output stability: while out_valid=1 and out_ready=0, out_data/out_ts hold.

Decomposition:
- Package wb_trace_pkg: DATA_W/TS_W/DROP_W defaults, entry width constant ENTRY_W=DATA_W+TS_W, and the entry struct/field-slice localparams.
- One sub-module, sync_fifo_fwft (width/depth parameterised storage, pointers, count, full/empty). The top holds the ts counter, drop logic and clear fan-out.

Test Plan:
- Reset release, then wb_valid pulses with data 0x00000005 at ts=3 -> out_valid=1 next cycle, out_data=0x5, out_ts=3, count=1.
- Push 16 values 0x100..0x10F with out_ready=0 -> count=16, no overflow. Drain with out_ready=1 -> values return in order with consecutive ts.
- Full FIFO plus 3 further wb_valid cycles, no pop -> overflow=1, drop_cnt=3, count=16, contents unchanged.
- Full FIFO with wb_valid and out_ready both high for 4 cycles -> 4 pops, 4 pushes, count stays 16, drop_cnt=0.
- Overflow 300 times with DROP_W=8 -> drop_cnt=255. Then clear together with wb_valid -> next cycle count=0, overflow=0, drop_cnt=0, out_valid=0.
- Run ts past 0xFFFF and capture at the wrap -> consecutive captures show ts 0xFFFF then 0x0000. Assert reset mid-drain -> out_valid drops to 0 asynchronously.
